// File: rtl/clkgate_pkg.sv
// Shared types for the clock-gating controller.
// Per-channel FSM state encoding.
`timescale 1ns/1ps
package clkgate_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } ch_state_t;

endpackage

// File: rtl/clkgate.sv
// Latch-based integrated clock gate cell.
// Enable is captured while clk is low, so lck never glitches.
`timescale 1ns/1ps
module clkgate (
    input  logic i_clk,
    input  logic i_en,
    input  logic i_se,
    output logic o_gclk
);

    logic r_en_lat;

    // Transparent on clk low; frozen for the whole high phase.
    always_latch begin
        if (!i_clk) r_en_lat <= i_en | i_se;
    end

    assign o_gclk = i_clk & r_en_lat;

endmodule

// File: rtl/clkgate_ch.sv
// One gated-clock channel: wake/idle FSM, hold-off counter, gate cell.
// active/ready are registered from the next state.
`timescale 1ns/1ps
module clkgate_ch
    import clkgate_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scan_mode,
    input  logic              i_sw_en,
    input  logic              i_busy,
    input  logic              i_force_on,
    input  logic [HOLD_W-1:0] i_hold,
    output logic              o_lck,
    output logic              o_ready,
    output logic              o_active
);

    ch_state_t         r_state;
    ch_state_t         w_state_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic              r_active;
    logic              r_ready;
    logic              w_req;

    assign w_req = i_busy | i_force_on;

    // Next-state and hold-off count; sw_en low wins in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_OFF: begin
                if (i_sw_en && w_req) w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                w_state_nxt = i_sw_en ? ST_ON : ST_OFF;
            end
            ST_ON: begin
                if (!i_sw_en) begin
                    w_state_nxt = ST_OFF;
                end else if (!w_req) begin
                    if (i_hold == '0) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = i_hold - HOLD_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (!i_sw_en) begin
                    w_state_nxt = ST_OFF;
                end else if (w_req) begin
                    w_state_nxt = ST_ON;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - HOLD_W'(1);
                end
            end
        endcase
    end

    // State, counter and registered gate enable / ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_OFF;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= (w_state_nxt != ST_OFF);
            r_ready  <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_HOLD);
        end
    end

    clkgate u_cg (
        .i_clk  (i_clk),
        .i_en   (r_active),
        .i_se   (i_scan_mode),
        .o_gclk (o_lck)
    );

    assign o_active = r_active;
    assign o_ready  = r_ready;

endmodule

// File: rtl/clkgate_ctrl.sv
// Multi-channel automatic clock-gating controller.
// One independent clkgate_ch per gated clock.
`timescale 1ns/1ps
module clkgate_ctrl
    import clkgate_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int HOLD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scan_mode,
    input  logic [NCH-1:0]    i_sw_en,
    input  logic [NCH-1:0]    i_busy,
    input  logic [NCH-1:0]    i_force_on,
    input  logic [HOLD_W-1:0] i_hold,
    output logic [NCH-1:0]    o_lck,
    output logic [NCH-1:0]    o_ready,
    output logic [NCH-1:0]    o_active
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkgate_ch #(
            .HOLD_W (HOLD_W)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_scan_mode (i_scan_mode),
            .i_sw_en     (i_sw_en[g]),
            .i_busy      (i_busy[g]),
            .i_force_on  (i_force_on[g]),
            .i_hold      (i_hold),
            .o_lck       (o_lck[g]),
            .o_ready     (o_ready[g]),
            .o_active    (o_active[g])
        );
    end

endmodule
